// File: rtl/nfm_pkg.sv
// Shared constants and types for the nonlinear-function datapath.
// Holds the 2^(k/4) segment table used by exp2_pwl.
package nfm_pkg;

  localparam int unsigned FIX_W  = 16;
  localparam int unsigned FRAC_W = 8;

  // Segment base c = 2^(k/4) and slope m, both Q.8
  localparam logic [8:0] EXP2_C [4] = '{9'd256, 9'd304, 9'd362, 9'd431};
  localparam logic [8:0] EXP2_M [4] = '{9'd192, 9'd232, 9'd276, 9'd324};

  localparam logic signed [7:0] EXP2_SAT_N  = 8'sd7;
  localparam logic signed [7:0] EXP2_ZERO_N = -8'sd9;

  localparam logic [FIX_W-1:0] FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};

  typedef struct packed {
    logic signed [7:0] n;
    logic [1:0]        k;
    logic [5:0]        r;
  } exp2_s1_t;

endpackage

// File: rtl/exp2_frac_lut.sv
// Piecewise-linear 2^f for f in [0,1): y = c_k + (m_k * r) >> 8, range 256..511.
module exp2_frac_lut
  import nfm_pkg::*;
(
  input  logic [1:0] i_k,
  input  logic [5:0] i_r,
  output logic [8:0] o_y
);

  logic [14:0] w_prod;

  assign w_prod = {6'b0, EXP2_M[i_k]} * {9'b0, i_r};
  assign o_y    = EXP2_C[i_k] + 9'(w_prod >> 8);

endmodule

// File: rtl/exp2_pwl.sv
// Three-stage base-2 exponential: split, fraction LUT, saturating barrel shift.
// Single global enable; the whole pipe freezes while the output is back-pressured.
module exp2_pwl
  import nfm_pkg::*;
#(
  parameter int unsigned Bf              = FRAC_W,
  parameter int unsigned FIX_POINT_WIDTH = FIX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out_data,
  output logic                       out_sat
);

  logic                       w_en;
  exp2_s1_t                   w_s1;
  logic [8:0]                 w_y;
  logic [FIX_POINT_WIDTH-1:0] w_y_ext;
  logic [7:0]                 w_neg;
  logic [FIX_POINT_WIDTH-1:0] w_res;
  logic                       w_sat;

  logic                       r_v1, r_v2, r_v3;
  exp2_s1_t                   r_s1;
  logic [8:0]                 r_y;
  logic signed [7:0]          r_n2;
  logic [FIX_POINT_WIDTH-1:0] r_out;
  logic                       r_sat;

  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  assign w_s1.n = in_data[FIX_POINT_WIDTH-1:Bf];
  assign w_s1.k = in_data[Bf-1:Bf-2];
  assign w_s1.r = in_data[Bf-3:0];

  exp2_frac_lut u_lut (
    .i_k (r_s1.k),
    .i_r (r_s1.r),
    .o_y (w_y)
  );

  assign w_y_ext = {{(FIX_POINT_WIDTH-9){1'b0}}, r_y};
  assign w_neg   = 8'(-r_n2);

  // y is always >= 256, so n >= 7 overflows and n <= -9 underflows to zero
  always_comb begin
    w_sat = 1'b0;
    w_res = '0;
    if (r_n2 >= EXP2_SAT_N) begin
      w_sat = 1'b1;
      w_res = FIX_MAX;
    end else if (r_n2 <= EXP2_ZERO_N) begin
      w_res = '0;
    end else if (!r_n2[7]) begin
      w_res = w_y_ext << r_n2[2:0];
    end else begin
      w_res = w_y_ext >> w_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_s1  <= '0;
      r_y   <= '0;
      r_n2  <= '0;
      r_out <= '0;
      r_sat <= 1'b0;
    end else if (w_en) begin
      r_v1  <= in_valid;
      r_s1  <= w_s1;
      r_v2  <= r_v1;
      r_y   <= w_y;
      r_n2  <= r_s1.n;
      r_v3  <= r_v2;
      r_out <= w_res;
      r_sat <= w_sat;
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_out;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_exp2_pwl.sv
// Bench for exp2_pwl: arithmetic reference model, scoreboard and valid-timing model.
module tb_exp2_pwl;

  typedef struct packed {
    logic        s;
    logic [15:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  always #5 clk = ~clk;

  exp2_pwl #(
    .Bf              (8),
    .FIX_POINT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  int n_vec  = 0;
  int n_miss = 0;

  res_t        exp_q[$];
  res_t        obs_q[$];
  logic [15:0] ops[$];

  logic [2:0]  vp;
  bit          chk_on     = 1'b0;
  bit          just_rst   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic        prev_s;

  // 2^x from the definition: floor integer part, 4-segment fraction, scale by 2^n
  function automatic res_t model(input logic [15:0] x);
    int   n, f, k, r, y;
    int   c[4] = '{256, 304, 362, 431};
    int   m[4] = '{192, 232, 276, 324};
    res_t o;
    n   = int'($signed(x[15:8]));
    f   = int'(x[7:0]);
    k   = f / 64;
    r   = f % 64;
    y   = c[k] + (m[k] * r) / 256;
    o.s = 1'b0;
    if (n >= 7) begin
      o.s = 1'b1;
      o.d = 16'h7fff;
    end else if (n >= 0) begin
      o.d = 16'(y * (1 << n));
    end else if (n <= -9) begin
      o.d = 16'h0;
    end else begin
      o.d = 16'(y / (1 << (-n)));
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pin(input logic [15:0] x, input logic [15:0] d, input logic s);
    res_t o;
    o = model(x);
    check($sformatf("model_%04h_data", x), 32'(o.d), 32'(d));
    check($sformatf("model_%04h_sat", x), 32'(o.s), 32'(s));
  endtask

  // Compare process: sampled on the falling edge, describes the coming rising edge
  always @(negedge clk) begin
    res_t e;
    bit   en_m;
    if (!rst_n) begin
      exp_q.delete();
      vp         = 3'b000;
      just_rst   = 1'b1;
      prev_stall = 1'b0;
      chk_on     = 1'b1;
    end else if (chk_on) begin
      en_m = !vp[2] || out_ready;
      check("out_valid", 32'(out_valid), 32'(vp[2]));
      check("in_ready", 32'(in_ready), 32'(en_m));
      if (just_rst) begin
        check("reset_out_data", 32'(out_data), 32'h0);
        check("reset_out_sat", 32'(out_sat), 32'h0);
        just_rst = 1'b0;
      end
      if (prev_stall) begin
        check("stall_hold_data", 32'(out_data), 32'(prev_d));
        check("stall_hold_sat", 32'(out_sat), 32'(prev_s));
      end
      if (vp[2] && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL scoreboard_empty: got %0h, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sat", 32'(out_sat), 32'(e.s));
          obs_q.push_back({out_sat, out_data});
        end
      end
      prev_stall = vp[2] && !out_ready;
      prev_d     = out_data;
      prev_s     = out_sat;
      if (en_m) begin
        if (in_valid) exp_q.push_back(model(in_data));
        vp = {vp[1:0], in_valid};
      end
    end
  end

  // Sends ops[] in order; out_ready is low for cycles [st_start, st_start+st_len)
  task automatic stream(input int st_start, input int st_len, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < ops.size() && cyc < ops.size() * 4 + 64) begin
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = ops[idx];
      out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    if (idx < ops.size()) begin
      n_vec++;
      n_miss++;
      $display("FAIL stream_timeout: sent %0d, expected %0d", idx, ops.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input res_t req[$]);
    check({name, "_count"}, 32'(obs_q.size()), 32'(req.size()));
    for (int i = 0; i < req.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_%0d_data", name, i), 32'(obs_q[i].d), 32'(req[i].d));
      check($sformatf("%s_%0d_sat", name, i), 32'(obs_q[i].s), 32'(req[i].s));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;

    pin(16'h0000, 16'd256,   1'b0);
    pin(16'h0100, 16'd512,   1'b0);
    pin(16'hFF00, 16'd128,   1'b0);
    pin(16'h0080, 16'd362,   1'b0);
    pin(16'h0680, 16'd23168, 1'b0);
    pin(16'h003F, 16'd303,   1'b0);
    pin(16'h0040, 16'd304,   1'b0);
    pin(16'h05FF, 16'd16320, 1'b0);
    pin(16'hF800, 16'd1,     1'b0);
    pin(16'h0700, 16'h7fff,  1'b1);
    pin(16'hF700, 16'd0,     1'b0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    ops = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080};
    obs_q.delete();
    stream(-1, 0, 1'b0);
    check_obs("basic", '{'{1'b0, 16'd256}, '{1'b0, 16'd512}, '{1'b0, 16'd128},
                         '{1'b0, 16'd362}});

    ops = '{16'h0680, 16'h003F, 16'h0040};
    obs_q.delete();
    stream(-1, 0, 1'b0);
    check_obs("segment", '{'{1'b0, 16'd23168}, '{1'b0, 16'd303}, '{1'b0, 16'd304}});

    ops = '{16'h0700, 16'h7FFF, 16'hF700, 16'h8000};
    obs_q.delete();
    stream(-1, 0, 1'b0);
    check_obs("saturate", '{'{1'b1, 16'h7fff}, '{1'b1, 16'h7fff}, '{1'b0, 16'h0000},
                            '{1'b0, 16'h0000}});

    ops = '{16'h0123, 16'h0234, 16'hFE80, 16'h0345, 16'h00C0, 16'h0456};
    obs_q.delete();
    stream(3, 4, 1'b0);
    check("stall_count", 32'(obs_q.size()), 32'd6);

    ops.delete();
    for (int i = 0; i < 24; i++) ops.push_back(16'($urandom));
    stream(-1, 0, 1'b1);

    // Reset with three operands in flight and the output back-pressured
    obs_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i * 256);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("reset_flush_count", 32'(obs_q.size()), 32'd0);

    ops.delete();
    for (int i = 0; i < 65536; i++) ops.push_back(16'(i));
    obs_q.delete();
    stream(-1, 0, 1'b0);
    check("sweep_count", 32'(obs_q.size()), 32'd65536);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
